addsub_seq: RTL and testbench
=============================

# addsub_seq

Command sequencer and accumulator wrapped around the 8-bit `addsub` datapath. It accepts LOAD/ADD/SUB/CLR commands over a valid/ready handshake and drives the `addsub` operand and mode inputs from registers. It captures the 9-bit `addsub` result into an 8-bit accumulator plus a carry/borrow flag, and returns each result on a valid/ready response channel. It is the control stage that feeds `addsub` directly and consumes its output.

## Interface
- No parameters; widths are fixed to match `addsub` (8-bit operands, 9-bit result).
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 CLR, 01 LOAD, 10 ADD, 11 SUB
- cmd_data  in  8  operand for LOAD/ADD/SUB
- as_a  out  8  to `addsub` a; registered
- as_b  out  8  to `addsub` b; registered
- as_addnsub  out  1  to `addsub` addnsub; registered; 1 = add, 0 = subtract
- as_result  in  9  from `addsub` result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  9  {flag, acc} after the command
- acc  out  8  current accumulator
- flag  out  1  carry (ADD) or borrow (SUB) of the last arithmetic op
- op_count  out  8  completed ADD/SUB count, wraps 255 -> 0

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: acc = 0, flag = 0, op_count = 0, as_a = 0, as_b = 0, as_addnsub = 1, rsp_valid = 0, rsp_data = 0. cmd_ready follows its definition (1 in IDLE).
- cmd_ready = 1 only in IDLE.
- In IDLE, a command is accepted when cmd_valid & cmd_ready.
  - ADD/SUB: load as_a <= acc, as_b <= cmd_data, as_addnsub <= (op == ADD); go to EXEC.
  - LOAD: acc <= cmd_data, flag <= 0; go to RESP.
  - CLR: acc <= 0, flag <= 0; go to RESP.
  - LOAD and CLR never use the datapath and do not change as_*.
- In EXEC, at the end of the cycle:
  - acc <= as_result[7:0], flag <= as_result[8].
  - op_count <= op_count + 1.
  - Go to RESP.
- RESP: rsp_valid = 1 and rsp_data = {flag, acc}, both held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
- `addsub` contract:
  - ADD: result = a + b, 9 bits.
  - SUB: result = {0,a} − {0,b} mod 2^9; result[8] = 1 means borrow (a < b).
- as_* hold their last values outside EXEC. The datapath is purely combinational, so as_result is valid throughout EXEC.

## Timing
- ADD/SUB latency: accept at edge 0, EXEC for cycle 1, rsp_valid high in cycle 2.
- LOAD/CLR latency: rsp_valid high in the cycle after acceptance.
- Minimum throughput: one command per 3 cycles for ADD/SUB and one per 2 cycles for LOAD/CLR, with rsp_ready tied high.
- A command is never accepted in the same cycle a response retires. cmd_ready rises the cycle after the RESP handshake.
- Backpressure: rsp_ready low holds RESP indefinitely. acc, flag and rsp_data do not change while held.
- Asynchronous reset in EXEC or RESP discards the command immediately: no response, op_count not incremented, all outputs at their reset values.

## Configuration
- ADDSUB_SEQ_SAT_EN defined: saturating accumulator.
  - ADD with as_result[8] = 1 writes acc = 0xFF.
  - SUB with as_result[8] = 1 writes acc = 0x00.
  - flag still records the raw as_result[8].
- Undefined: acc = as_result[7:0] (modular wrap).

## Test plan
- Reset, then LOAD 0x10 and ADD 0x05 -> as_a = 0x10, as_b = 0x05, as_addnsub = 1 in EXEC; response 0x015; op_count = 1.
- acc = 0xF0, ADD 0x20 -> without SAT: response 0x110 (acc 0x10, flag 1); with SAT: acc 0xFF, flag 1.
- acc = 0x03, SUB 0x05 -> without SAT: response 0x1FE; with SAT: acc 0x00, flag 1. acc = 0x05, SUB 0x03 -> 0x002.
- Hold rsp_ready low for 5 cycles after an ADD -> rsp_valid and rsp_data stable and cmd_ready = 0 throughout; one handshake on release; cmd_ready = 1 the next cycle.
- Issue 256 ADD 0x00 commands -> op_count wraps to 0. A CLR then LOAD sequence leaves op_count unchanged.
- Assert rst_n low during EXEC of SUB 0x01 -> no rsp_valid; acc, flag and op_count = 0; cmd_ready = 1 after release.

Source files
------------

// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq
//
// Command sequencer and accumulator that sits in front of the 8-bit `addsub`
// combinational datapath. Commands (CLR / LOAD / ADD / SUB) arrive over a
// valid/ready channel. ADD and SUB drive the datapath operands and mode from
// registers. The 9-bit datapath result is captured into an 8-bit accumulator
// plus a carry/borrow flag. Every command produces exactly one response
// ({flag, acc}) on a valid/ready response channel.
//
// Configuration macro:
//   ADDSUB_SEQ_SAT_EN  - when defined, the accumulator saturates. An ADD
//                        carry writes 0xFF and a SUB borrow writes 0x00. The
//                        flag still records the raw result[8]. When not
//                        defined, the accumulator wraps (modular arithmetic).
//
// Ports:
//   clk         in   1  sole clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   cmd_valid   in   1  command present
//   cmd_ready   out  1  sequencer can accept a command (IDLE only)
//   cmd_op      in   2  00 CLR, 01 LOAD, 10 ADD, 11 SUB
//   cmd_data    in   8  operand for LOAD/ADD/SUB
//   as_a        out  8  datapath operand a (registered)
//   as_b        out  8  datapath operand b (registered)
//   as_addnsub  out  1  datapath mode, 1 = add, 0 = subtract (registered)
//   as_result   in   9  datapath result
//   rsp_valid   out  1  response available
//   rsp_ready   in   1  consumer takes response
//   rsp_data    out  9  {flag, acc} after the command
//   acc         out  8  current accumulator
//   flag        out  1  carry (ADD) / borrow (SUB) of last arithmetic op
//   op_count    out  8  completed ADD/SUB count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module addsub_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] as_a,
  output logic [7:0] as_b,
  output logic       as_addnsub,
  input  logic [8:0] as_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_data,
  output logic [7:0] acc,
  output logic       flag,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic       flag_q, flag_d;
  logic [7:0] op_count_q, op_count_d;
  logic [7:0] as_a_q, as_a_d;
  logic [7:0] as_b_q, as_b_d;
  logic       as_addnsub_q, as_addnsub_d;

  logic       cmd_fire;
  logic       rsp_fire;
  logic [7:0] exec_acc;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  assign cmd_fire = cmd_valid & cmd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          // CLR and LOAD never touch the datapath, so they skip EXEC.
          if (cmd_op == OP_ADD || cmd_op == OP_SUB) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Returning to IDLE (not straight to another accept) means cmd_ready
        // only rises the cycle after the response retires.
        if (rsp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (state-decoded handshake outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 9'd0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_RESP: begin
        // acc/flag cannot change in RESP, so rsp_data is stable under
        // backpressure without a separate holding register.
        rsp_valid = 1'b1;
        rsp_data  = {flag_q, acc_q};
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator value written at the end of EXEC
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef ADDSUB_SEQ_SAT_EN
    // Clamp on overflow: a carry on ADD pins the accumulator high. A borrow
    // on SUB pins it low. as_addnsub_q tells us which operation is in flight.
    if (as_result[8]) begin
      exec_acc = as_addnsub_q ? 8'hFF : 8'h00;
    end else begin
      exec_acc = as_result[7:0];
    end
`else
    exec_acc = as_result[7:0];
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath register next values
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d        = acc_q;
    flag_d       = flag_q;
    op_count_d   = op_count_q;
    as_a_d       = as_a_q;
    as_b_d       = as_b_q;
    as_addnsub_d = as_addnsub_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_CLR: begin
              acc_d  = 8'h00;
              flag_d = 1'b0;
            end
            OP_LOAD: begin
              acc_d  = cmd_data;
              flag_d = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              // The datapath operands come from registers, so as_result is
              // settled for the whole EXEC cycle.
              as_a_d       = acc_q;
              as_b_d       = cmd_data;
              as_addnsub_d = (cmd_op == OP_ADD);
            end
            default: begin
              acc_d = acc_q;
            end
          endcase
        end
      end
      ST_EXEC: begin
        acc_d      = exec_acc;
        flag_d     = as_result[8];
        op_count_d = op_count_q + 8'd1;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // A reset in EXEC or RESP clears everything, so the in-flight command is
  // dropped without a response or a count increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= 8'h00;
      flag_q       <= 1'b0;
      op_count_q   <= 8'h00;
      as_a_q       <= 8'h00;
      as_b_q       <= 8'h00;
      as_addnsub_q <= 1'b1;
    end else begin
      acc_q        <= acc_d;
      flag_q       <= flag_d;
      op_count_q   <= op_count_d;
      as_a_q       <= as_a_d;
      as_b_q       <= as_b_d;
      as_addnsub_q <= as_addnsub_d;
    end
  end

  assign as_a       = as_a_q;
  assign as_b       = as_b_q;
  assign as_addnsub = as_addnsub_q;
  assign acc        = acc_q;
  assign flag       = flag_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_addsub_seq
//
// Self-checking bench for addsub_seq. It models the combinational `addsub`
// datapath and keeps a reference accumulator. Expected responses are pushed to
// a queue when a command is driven. They are popped and compared when the
// DUT raises rsp_valid. Honours ADDSUB_SEQ_SAT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_addsub_seq;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] as_a;
  logic [7:0] as_b;
  logic       as_addnsub;
  logic [8:0] as_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_data;
  logic [7:0] acc;
  logic       flag;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] model_acc;
  logic       model_flag;
  logic [7:0] model_count;
  logic [8:0] exp_q[$];

  addsub_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .as_a       (as_a),
    .as_b       (as_b),
    .as_addnsub (as_addnsub),
    .as_result  (as_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .acc        (acc),
    .flag       (flag),
    .op_count   (op_count)
  );

  // External `addsub` datapath
  assign as_result = as_addnsub ? ({1'b0, as_a} + {1'b0, as_b})
                                : ({1'b0, as_a} - {1'b0, as_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_apply(input logic [1:0] op, input logic [7:0] d);
    logic [8:0] r;
    case (op)
      OP_CLR:  begin model_acc = 8'h00; model_flag = 1'b0; end
      OP_LOAD: begin model_acc = d;     model_flag = 1'b0; end
      default: begin
        if (op == OP_ADD) r = {1'b0, model_acc} + {1'b0, d};
        else              r = {1'b0, model_acc} - {1'b0, d};
        model_flag = r[8];
`ifdef ADDSUB_SEQ_SAT_EN
        if (r[8]) model_acc = (op == OP_ADD) ? 8'hFF : 8'h00;
        else      model_acc = r[7:0];
`else
        model_acc = r[7:0];
`endif
        model_count = model_count + 8'd1;
      end
    endcase
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_CLR;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    model_acc   = 8'h00;
    model_flag  = 1'b0;
    model_count = 8'h00;
    exp_q.delete();
  endtask

  // Drive one command and return #1 after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    int waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_ready_timeout op=%0d actual cmd_ready=%b required 1", op, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid at negedges; lat = negedges after acceptance.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic check_rsp(input string name);
    logic [8:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected response actual=%h required none", name, rsp_data);
    end else begin
      exp = exp_q.pop_front();
      if (rsp_data !== exp) begin
        errors++;
        $display("FAIL %s rsp_data actual=%h required %h", name, rsp_data, exp);
      end
    end
  endtask

  // Full command round trip with rsp_ready high.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input string name);
    logic [7:0] prev_acc;
    int lat;
    int exp_lat;
    bit arith;
    arith    = (op == OP_ADD) || (op == OP_SUB);
    exp_lat  = arith ? 2 : 1;
    prev_acc = model_acc;
    model_apply(op, d);
    exp_q.push_back({model_flag, model_acc});
    send_cmd(op, d);
    if (arith) begin
      @(negedge clk);
      checks++;
      if (as_a !== prev_acc || as_b !== d || as_addnsub !== (op == OP_ADD) || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s exec actual a=%h b=%h m=%b v=%b required a=%h b=%h m=%b v=0",
                 name, as_a, as_b, as_addnsub, rsp_valid, prev_acc, d, (op == OP_ADD));
      end
      wait_valid(lat);
      lat++;
    end else begin
      wait_valid(lat);
    end
    checks++;
    if (!rsp_valid || lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency actual=%0d valid=%b required %0d", name, lat, rsp_valid, exp_lat);
    end
    check_rsp(name);
    checks++;
    if (op_count !== model_count || acc !== model_acc || flag !== model_flag) begin
      errors++;
      $display("FAIL %s state actual cnt=%h acc=%h flag=%b required cnt=%h acc=%h flag=%b",
               name, op_count, acc, flag, model_count, model_acc, model_flag);
    end
    $display("txn %s op=%0d data=%h rsp=%h cnt=%0d", name, op, d, rsp_data, op_count);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (acc !== 8'h00 || flag !== 1'b0 || op_count !== 8'h00 || as_a !== 8'h00 ||
        as_b !== 8'h00 || as_addnsub !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_data !== 9'h000 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state actual acc=%h f=%b cnt=%h a=%h b=%h m=%b v=%b d=%h r=%b required 00 0 00 00 00 1 0 000 1",
               acc, flag, op_count, as_a, as_b, as_addnsub, rsp_valid, rsp_data, cmd_ready);
    end
    $display("txn reset acc=%h cnt=%h cmd_ready=%b", acc, op_count, cmd_ready);
  endtask

  task automatic test_load_add();
    do_cmd(OP_LOAD, 8'h10, "load10");
    do_cmd(OP_ADD,  8'h05, "add05");
    checks++;
    if (op_count !== 8'd1) begin
      errors++;
      $display("FAIL first_op_count actual=%0d required 1", op_count);
    end
  endtask

  task automatic test_carry();
    do_cmd(OP_LOAD, 8'hF0, "loadF0");
    do_cmd(OP_ADD,  8'h20, "add_carry");
  endtask

  task automatic test_borrow();
    do_cmd(OP_LOAD, 8'h03, "load03");
    do_cmd(OP_SUB,  8'h05, "sub_borrow");
    do_cmd(OP_LOAD, 8'h05, "load05");
    do_cmd(OP_SUB,  8'h03, "sub_plain");
    do_cmd(OP_CLR,  8'hAA, "clr");
  endtask

  task automatic test_backpressure();
    int lat;
    logic [8:0] held;
    model_apply(OP_ADD, 8'h07);
    exp_q.push_back({model_flag, model_acc});
    rsp_ready = 1'b0;
    send_cmd(OP_ADD, 8'h07);
    wait_valid(lat);
    held = rsp_data;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;  // must not be accepted while the response is held
      cmd_op    = OP_LOAD;
      cmd_data  = 8'h99;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || acc !== model_acc) begin
        errors++;
        $display("FAIL backpressure_hold cycle=%0d actual v=%b d=%h r=%b acc=%h required v=1 d=%h r=0 acc=%h",
                 i, rsp_valid, rsp_data, cmd_ready, acc, held, model_acc);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check_rsp("backpressure");
    $display("txn backpressure rsp=%h", rsp_data);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || acc !== model_acc) begin
      errors++;
      $display("FAIL backpressure_release actual v=%b r=%b acc=%h required v=0 r=1 acc=%h",
               rsp_valid, cmd_ready, acc, model_acc);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 255; i++) do_cmd(OP_ADD, 8'h00, "add00");
    checks++;
    if (op_count !== 8'd255) begin
      errors++;
      $display("FAIL count_255 actual=%0d required 255", op_count);
    end
    do_cmd(OP_ADD, 8'h00, "add00_wrap");
    checks++;
    if (op_count !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap actual=%0d required 0", op_count);
    end
    do_cmd(OP_LOAD, 8'h33, "load33");
    do_cmd(OP_ADD,  8'h01, "add01");
    do_cmd(OP_CLR,  8'h00, "clr2");
    do_cmd(OP_LOAD, 8'h44, "load44");
    checks++;
    if (op_count !== 8'd1) begin
      errors++;
      $display("FAIL count_clr_load actual=%0d required 1", op_count);
    end
  endtask

  task automatic test_reset_exec();
    do_cmd(OP_LOAD, 8'h22, "load22");
    model_apply(OP_SUB, 8'h01);
    exp_q.push_back({model_flag, model_acc});
    send_cmd(OP_SUB, 8'h01);
    @(negedge clk);  // mid EXEC
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || acc !== 8'h00 || flag !== 1'b0 || op_count !== 8'h00 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_exec actual v=%b acc=%h f=%b cnt=%h r=%b required 0 00 0 00 1",
               rsp_valid, acc, flag, op_count, cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    model_acc   = 8'h00;
    model_flag  = 1'b0;
    model_count = 8'h00;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 8'h00) begin
        errors++;
        $display("FAIL reset_exec_after cycle=%0d actual v=%b r=%b cnt=%h required v=0 r=1 cnt=00",
                 i, rsp_valid, cmd_ready, op_count);
      end
    end
    $display("txn reset_in_exec acc=%h cnt=%h", acc, op_count);
    do_cmd(OP_ADD, 8'h09, "add_after_reset");
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_carry();
    test_borrow();
    test_backpressure();
    test_wrap();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
